// File: rtl/i2c_bit_timer_if.sv
// -----------------------------------------------------------------------------
// i2c_bit_timer_if
//
// Purpose:
//   Groups the framing-timer signals between the SCL/SDA edge detectors, the
//   bit timer and the slave controller FSM. Signal names carry the direction
//   as seen from the bit timer (i_ = into the timer, o_ = out of the timer).
//
// Signals:
//   i_scl_rise       one-cycle pulse, synchronized SCL rising edge
//   i_scl_fall       one-cycle pulse, synchronized SCL falling edge
//   i_start_found    one-cycle pulse, START or repeated START detected
//   i_stop_found     one-cycle pulse, STOP detected
//   o_byte_received  pulse, last data bit of the byte sampled
//   o_ack_prep       pulse, SCL fell after last data bit (drive ACK now)
//   o_ack_check      pulse, SCL rose in ACK slot (SDA holds ACK/NACK)
//   o_ack_done       pulse, SCL fell ending the ACK slot
//   o_bit_count      data bits sampled in the current byte
//   o_framing_active high from START until STOP
//   o_timeout        pulse, bus stalled too long (only with
//                    I2C_BIT_TIMER_TIMEOUT_EN defined)
//
// Modports:
//   slave  - the bit timer itself
//   master - the surrounding logic that feeds edges and consumes strobes
//
// Optional feature macro: I2C_BIT_TIMER_TIMEOUT_EN
// -----------------------------------------------------------------------------
interface i2c_bit_timer_if;
   logic       i_scl_rise;
   logic       i_scl_fall;
   logic       i_start_found;
   logic       i_stop_found;
   logic       o_byte_received;
   logic       o_ack_prep;
   logic       o_ack_check;
   logic       o_ack_done;
   logic [3:0] o_bit_count;
   logic       o_framing_active;
`ifdef I2C_BIT_TIMER_TIMEOUT_EN
   logic       o_timeout;

   modport slave (
      input  i_scl_rise, i_scl_fall, i_start_found, i_stop_found,
      output o_byte_received, o_ack_prep, o_ack_check, o_ack_done,
      output o_bit_count, o_framing_active, o_timeout
   );

   modport master (
      output i_scl_rise, i_scl_fall, i_start_found, i_stop_found,
      input  o_byte_received, o_ack_prep, o_ack_check, o_ack_done,
      input  o_bit_count, o_framing_active, o_timeout
   );
`else
   modport slave (
      input  i_scl_rise, i_scl_fall, i_start_found, i_stop_found,
      output o_byte_received, o_ack_prep, o_ack_check, o_ack_done,
      output o_bit_count, o_framing_active
   );

   modport master (
      output i_scl_rise, i_scl_fall, i_start_found, i_stop_found,
      input  o_byte_received, o_ack_prep, o_ack_check, o_ack_done,
      input  o_bit_count, o_framing_active
   );
`endif
endinterface : i2c_bit_timer_if

// File: rtl/i2c_bit_timer.sv
// -----------------------------------------------------------------------------
// i2c_bit_timer
//
// Purpose:
//   Slave-side bit/byte framing timer. Counts SCL rising edges after a START
//   and emits single-cycle framing strobes (byte_received, ack_prep,
//   ack_check, ack_done) that the slave controller uses to sequence address
//   check, data shifting and the ACK/NACK slot. Repeated START restarts the
//   byte; STOP returns to idle.
//
// Parameters:
//   BITS_PER_BYTE   data SCL rising edges per byte before the ACK slot (1..15)
//   TIMEOUT_CYCLES  clock cycles without bus activity before the timer gives
//                   up (only with I2C_BIT_TIMER_TIMEOUT_EN defined)
//
// Ports:
//   clk     system clock
//   n_rst   asynchronous active-low reset
//   io_bus  i2c_bit_timer_if.slave, edge pulses in, framing strobes out
//
// Optional feature macro: I2C_BIT_TIMER_TIMEOUT_EN
//   Adds a 16-bit inactivity counter and the o_timeout strobe. Without it the
//   FSM waits indefinitely for the next SCL edge.
//
// All outputs are registered: a strobe caused by an input pulse sampled at
// clock edge N is high for exactly the cycle following edge N.
// -----------------------------------------------------------------------------
module i2c_bit_timer #(
   parameter int BITS_PER_BYTE = 8
`ifdef I2C_BIT_TIMER_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 1000
`endif
) (
   input  logic           clk,
   input  logic           n_rst,
   i2c_bit_timer_if.slave io_bus
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DATA      = 3'd1,
      ST_WAIT_FALL = 3'd2,
      ST_ACK_LOW   = 3'd3,
      ST_ACK_HIGH  = 3'd4
   } state_t;

   localparam logic [3:0] LP_LAST_BIT = 4'(BITS_PER_BYTE);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_bit_count;
   logic [3:0] w_bit_count_nxt;
   logic       r_framing_active;
   logic       w_framing_active_nxt;
   logic       r_byte_received;
   logic       w_byte_received_nxt;
   logic       r_ack_prep;
   logic       w_ack_prep_nxt;
   logic       r_ack_check;
   logic       w_ack_check_nxt;
   logic       r_ack_done;
   logic       w_ack_done_nxt;

   logic       w_rise;
   logic       w_fall;
   logic       w_start;
   logic       w_stop;
   logic [3:0] w_count_inc;

   // A simultaneous rise and fall is illegal; the rise wins and the fall is
   // dropped, so every consumer of a falling edge uses the masked version.
   assign w_rise      = io_bus.i_scl_rise;
   assign w_fall      = io_bus.i_scl_fall & ~io_bus.i_scl_rise;
   assign w_start     = io_bus.i_start_found;
   assign w_stop      = io_bus.i_stop_found;
   assign w_count_inc = r_bit_count + 4'd1;

`ifdef I2C_BIT_TIMER_TIMEOUT_EN
   logic [15:0] r_to_cnt;
   logic [15:0] w_to_cnt_nxt;
   logic        r_timeout;
   logic        w_timeout_nxt;
   logic        w_to_event;
   logic [16:0] w_to_next;
   logic        w_to_hit;

   // Any bus event proves the master is alive, including a raw scl_fall that
   // the FSM itself would drop.
   assign w_to_event = io_bus.i_scl_rise | io_bus.i_scl_fall | w_start | w_stop;
   assign w_to_next  = {1'b0, r_to_cnt} + 17'd1;
   assign w_to_hit   = (r_state != ST_IDLE) && !w_to_event &&
                       (w_to_next == 17'(TIMEOUT_CYCLES));

   always_comb begin
      if (w_to_event || (r_state == ST_IDLE) || w_to_hit) begin
         w_to_cnt_nxt = '0;
      end else begin
         w_to_cnt_nxt = w_to_next[15:0];
      end
   end
`endif

   // Next-state and next-output logic.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      w_state_nxt          = r_state;
      w_bit_count_nxt      = r_bit_count;
      w_framing_active_nxt = r_framing_active;
      w_byte_received_nxt  = 1'b0;
      w_ack_prep_nxt       = 1'b0;
      w_ack_check_nxt      = 1'b0;
      w_ack_done_nxt       = 1'b0;
`ifdef I2C_BIT_TIMER_TIMEOUT_EN
      w_timeout_nxt        = 1'b0;
`endif

      // STOP outranks START, which outranks SCL edges; neither emits a strobe.
      if (w_stop) begin
         w_state_nxt          = ST_IDLE;
         w_bit_count_nxt      = '0;
         w_framing_active_nxt = 1'b0;
      end else if (w_start) begin
         w_state_nxt          = ST_DATA;
         w_bit_count_nxt      = '0;
         w_framing_active_nxt = 1'b1;
      end
`ifdef I2C_BIT_TIMER_TIMEOUT_EN
      else if (w_to_hit) begin
         w_state_nxt          = ST_IDLE;
         w_bit_count_nxt      = '0;
         w_framing_active_nxt = 1'b0;
         w_timeout_nxt        = 1'b1;
      end
`endif
      else begin
         unique case (r_state)
            ST_IDLE: begin
               // SCL edges outside a framed transfer are ignored.
            end
            ST_DATA: begin
               if (w_rise) begin
                  w_bit_count_nxt = w_count_inc;
                  if (w_count_inc == LP_LAST_BIT) begin
                     w_byte_received_nxt = 1'b1;
                     w_state_nxt         = ST_WAIT_FALL;
                  end
               end
            end
            ST_WAIT_FALL: begin
               if (w_fall) begin
                  w_ack_prep_nxt = 1'b1;
                  w_state_nxt    = ST_ACK_LOW;
               end
            end
            ST_ACK_LOW: begin
               if (w_rise) begin
                  w_ack_check_nxt = 1'b1;
                  w_state_nxt     = ST_ACK_HIGH;
               end
            end
            ST_ACK_HIGH: begin
               if (w_fall) begin
                  w_ack_done_nxt  = 1'b1;
                  w_bit_count_nxt = '0;
                  w_state_nxt     = ST_DATA;
               end
            end
            default: begin
               w_state_nxt          = ST_IDLE;
               w_bit_count_nxt      = '0;
               w_framing_active_nxt = 1'b0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state          <= ST_IDLE;
         r_bit_count      <= '0;
         r_framing_active <= 1'b0;
         r_byte_received  <= 1'b0;
         r_ack_prep       <= 1'b0;
         r_ack_check      <= 1'b0;
         r_ack_done       <= 1'b0;
`ifdef I2C_BIT_TIMER_TIMEOUT_EN
         r_to_cnt         <= '0;
         r_timeout        <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples values
         // from before this edge, independent of statement order.
         r_state          <= w_state_nxt;
         r_bit_count      <= w_bit_count_nxt;
         r_framing_active <= w_framing_active_nxt;
         r_byte_received  <= w_byte_received_nxt;
         r_ack_prep       <= w_ack_prep_nxt;
         r_ack_check      <= w_ack_check_nxt;
         r_ack_done       <= w_ack_done_nxt;
`ifdef I2C_BIT_TIMER_TIMEOUT_EN
         r_to_cnt         <= w_to_cnt_nxt;
         r_timeout        <= w_timeout_nxt;
`endif
      end
   end

   assign io_bus.o_byte_received  = r_byte_received;
   assign io_bus.o_ack_prep       = r_ack_prep;
   assign io_bus.o_ack_check      = r_ack_check;
   assign io_bus.o_ack_done       = r_ack_done;
   assign io_bus.o_bit_count      = r_bit_count;
   assign io_bus.o_framing_active = r_framing_active;
`ifdef I2C_BIT_TIMER_TIMEOUT_EN
   assign io_bus.o_timeout        = r_timeout;
`endif

   // Structural invariants: the strobes are mutually exclusive and the bit
   // counter never runs past the byte length.
   a_strobe_onehot : assert property (@(posedge clk) disable iff (!n_rst)
      $onehot0({r_byte_received, r_ack_prep, r_ack_check, r_ack_done}));

   a_count_bound : assert property (@(posedge clk) disable iff (!n_rst)
      r_bit_count <= LP_LAST_BIT);

endmodule : i2c_bit_timer

// File: tb/tb_i2c_bit_timer.sv
// -----------------------------------------------------------------------------
// tb_i2c_bit_timer
//
// Self-checking bench for i2c_bit_timer. Each stimulus step pushes the outputs
// the scenario expects after the next clock edge onto a scoreboard queue; the
// outputs are sampled 1 time unit after that edge, popped and compared.
// Define I2C_BIT_TIMER_TIMEOUT_EN to also exercise the timeout feature with
// TIMEOUT_CYCLES = 20.
// -----------------------------------------------------------------------------
module tb_i2c_bit_timer;

   localparam int BPB = 8;

   // Strobe vector layout: {byte_received, ack_prep, ack_check, ack_done}.
   localparam logic [3:0] S_NONE = 4'b0000;
   localparam logic [3:0] S_BR   = 4'b1000;
   localparam logic [3:0] S_AP   = 4'b0100;
   localparam logic [3:0] S_AC   = 4'b0010;
   localparam logic [3:0] S_AD   = 4'b0001;

   typedef struct packed {
      logic [3:0] stb;
      logic [3:0] cnt;
      logic       fa;
      logic       to;
   } obs_t;

   logic clk = 1'b0;
   logic n_rst;

   i2c_bit_timer_if bus();

   i2c_bit_timer #(
      .BITS_PER_BYTE(BPB)
`ifdef I2C_BIT_TIMER_TIMEOUT_EN
      ,.TIMEOUT_CYCLES(20)
`endif
   ) dut (
      .clk    (clk),
      .n_rst  (n_rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_br = 0;
   int   n_ap = 0;
   int   n_ac = 0;
   int   n_ad = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.stb = {bus.o_byte_received, bus.o_ack_prep, bus.o_ack_check, bus.o_ack_done};
      o.cnt = bus.o_bit_count;
      o.fa  = bus.o_framing_active;
`ifdef I2C_BIT_TIMER_TIMEOUT_EN
      o.to  = bus.o_timeout;
`else
      o.to  = 1'b0;
`endif
      return o;
   endfunction

   task automatic expect_out(input logic [3:0] stb, input logic [3:0] cnt,
                             input logic fa, input logic to);
      obs_t e;
      e.stb = stb;
      e.cnt = cnt;
      e.fa  = fa;
      e.to  = to;
      exp_q.push_back(e);
   endtask

   task automatic compare_out(input string tag);
      obs_t a;
      obs_t e;
      a = sample();
      n_br += int'(a.stb[3]);
      n_ap += int'(a.stb[2]);
      n_ac += int'(a.stb[1]);
      n_ad += int'(a.stb[0]);
      if (exp_q.size() == 0) begin
         check({tag, "/no_expectation"}, 32'(a), 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         check(tag, 32'(a), 32'(e));
      end
   endtask

   // One clock of stimulus: drive pulses, push expectation, compare after edge.
   task automatic step(input string tag, input logic r, input logic f,
                       input logic s, input logic p, input logic [3:0] stb,
                       input logic [3:0] cnt, input logic fa, input logic to = 1'b0);
      @(negedge clk);
      bus.i_scl_rise    = r;
      bus.i_scl_fall    = f;
      bus.i_start_found = s;
      bus.i_stop_found  = p;
      expect_out(stb, cnt, fa, to);
      @(posedge clk);
      #1;
      bus.i_scl_rise    = 1'b0;
      bus.i_scl_fall    = 1'b0;
      bus.i_start_found = 1'b0;
      bus.i_stop_found  = 1'b0;
      compare_out(tag);
   endtask

   task automatic idle(input string tag, input int n, input logic [3:0] cnt, input logic fa);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0, S_NONE, cnt, fa);
   endtask

   // Data bits first..last as rise/gap/fall/gap; the last bit of the byte
   // raises byte_received on its rise and ack_prep on the following fall.
   task automatic data_bits(input int first, input int last);
      for (int k = first; k <= last; k++) begin
         step("data_rise", 1'b1, 1'b0, 1'b0, 1'b0, (k == BPB) ? S_BR : S_NONE, 4'(k), 1'b1);
         idle("data_gap", 1, 4'(k), 1'b1);
         step("data_fall", 1'b0, 1'b1, 1'b0, 1'b0, (k == BPB) ? S_AP : S_NONE, 4'(k), 1'b1);
         idle("data_gap", 1, 4'(k), 1'b1);
      end
   endtask

   task automatic ack_slot();
      step("ack_rise", 1'b1, 1'b0, 1'b0, 1'b0, S_AC, 4'(BPB), 1'b1);
      idle("ack_gap", 1, 4'(BPB), 1'b1);
      step("ack_fall", 1'b0, 1'b1, 1'b0, 1'b0, S_AD, 4'd0, 1'b1);
      idle("ack_gap", 1, 4'd0, 1'b1);
   endtask

   initial begin
      n_rst             = 1'b0;
      bus.i_scl_rise    = 1'b0;
      bus.i_scl_fall    = 1'b0;
      bus.i_start_found = 1'b0;
      bus.i_stop_found  = 1'b0;

      // Reset state.
      #2;
      expect_out(S_NONE, 4'd0, 1'b0, 1'b0);
      compare_out("reset_state");
      @(negedge clk);
      n_rst = 1'b1;
      idle("post_reset", 2, 4'd0, 1'b0);

      // SCL edges before any START are ignored.
      step("idle_rise", 1'b1, 1'b0, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0);
      step("idle_fall", 1'b0, 1'b1, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0);

      // Two back-to-back bytes, no STOP in between.
      n_br = 0; n_ap = 0; n_ac = 0; n_ad = 0;
      step("start", 1'b0, 1'b0, 1'b1, 1'b0, S_NONE, 4'd0, 1'b1);
      data_bits(1, BPB);
      ack_slot();
      data_bits(1, BPB);
      ack_slot();
      check("count_byte_received", 32'(n_br), 32'd2);
      check("count_ack_prep",      32'(n_ap), 32'd2);
      check("count_ack_check",     32'(n_ac), 32'd2);
      check("count_ack_done",      32'(n_ad), 32'd2);
      step("stop", 1'b0, 1'b0, 1'b0, 1'b1, S_NONE, 4'd0, 1'b0);

      // Repeated START after the 5th rise restarts the byte.
      step("start2", 1'b0, 1'b0, 1'b1, 1'b0, S_NONE, 4'd0, 1'b1);
      data_bits(1, 4);
      step("rise5", 1'b1, 1'b0, 1'b0, 1'b0, S_NONE, 4'd5, 1'b1);
      step("rep_start", 1'b0, 1'b0, 1'b1, 1'b0, S_NONE, 4'd0, 1'b1);
      data_bits(1, BPB);
      ack_slot();
      step("stop2", 1'b0, 1'b0, 1'b0, 1'b1, S_NONE, 4'd0, 1'b0);

      // Simultaneous rise+fall counts as a rise; STOP beats START.
      step("start3", 1'b0, 1'b0, 1'b1, 1'b0, S_NONE, 4'd0, 1'b1);
      step("rise_and_fall", 1'b1, 1'b1, 1'b0, 1'b0, S_NONE, 4'd1, 1'b1);
      step("fall_only", 1'b0, 1'b1, 1'b0, 1'b0, S_NONE, 4'd1, 1'b1);
      step("stop_and_start", 1'b0, 1'b0, 1'b1, 1'b1, S_NONE, 4'd0, 1'b0);

      // STOP in ACK_LOW: no ack_check, later edges ignored.
      step("start4", 1'b0, 1'b0, 1'b1, 1'b0, S_NONE, 4'd0, 1'b1);
      data_bits(1, BPB);
      step("stop_ack_low", 1'b0, 1'b0, 1'b0, 1'b1, S_NONE, 4'd0, 1'b0);
      step("after_stop_rise", 1'b1, 1'b0, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0);
      step("after_stop_fall", 1'b0, 1'b1, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0);
      step("after_stop_rise2", 1'b1, 1'b0, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0);

      // Asynchronous reset mid-byte.
      step("start5", 1'b0, 1'b0, 1'b1, 1'b0, S_NONE, 4'd0, 1'b1);
      data_bits(1, 2);
      step("rise3", 1'b1, 1'b0, 1'b0, 1'b0, S_NONE, 4'd3, 1'b1);
      #2;
      n_rst = 1'b0;
      #1;
      expect_out(S_NONE, 4'd0, 1'b0, 1'b0);
      compare_out("async_reset");
      @(negedge clk);
      n_rst = 1'b1;
      step("rst_rise", 1'b1, 1'b0, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0);
      step("rst_fall", 1'b0, 1'b1, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0);
      step("rst_rise2", 1'b1, 1'b0, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0);

`ifdef I2C_BIT_TIMER_TIMEOUT_EN
      // No SCL activity after START: timeout on the 20th cycle.
      step("to_start", 1'b0, 1'b0, 1'b1, 1'b0, S_NONE, 4'd0, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         step("to_wait", 1'b0, 1'b0, 1'b0, 1'b0, S_NONE, 4'd0, (i < 20), (i == 20));
      end
      step("to_after", 1'b0, 1'b0, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0);
      step("to_idle_rise", 1'b1, 1'b0, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0);

      // An edge every 10 cycles keeps the timer alive.
      step("ka_start", 1'b0, 1'b0, 1'b1, 1'b0, S_NONE, 4'd0, 1'b1);
      for (int j = 0; j < 5; j++) begin
         idle("ka_wait", 9, 4'd0, 1'b1);
         step("ka_fall", 1'b0, 1'b1, 1'b0, 1'b0, S_NONE, 4'd0, 1'b1);
      end
      step("ka_stop", 1'b0, 1'b0, 1'b0, 1'b1, S_NONE, 4'd0, 1'b0);
`endif

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_i2c_bit_timer

// File: doc/i2c_bit_timer.md
Name: i2c_bit_timer

Overview:
- Slave-side bit/byte framing timer; sits between the SCL/SDA edge detectors and the main slave controller FSM.
- Counts SCL rising edges after START and produces single-cycle framing strobes: byte_received, ack_prep, ack_check, ack_done.
- The controller uses these strobes to sequence address check, data shifting and the ACK/NACK slot. Tracks repeated START and STOP.

Parameters:
- BITS_PER_BYTE, 8, number of data SCL rising edges per byte before the ACK slot (legal 1..15).

Ports:
- clk  input  1  system clock
- n_rst  input  1  reset, asynchronous, active-low
- scl_rise  input  1  one-cycle pulse: synchronized SCL rising edge
- scl_fall  input  1  one-cycle pulse: synchronized SCL falling edge
- start_found  input  1  one-cycle pulse: START or repeated START detected
- stop_found  input  1  one-cycle pulse: STOP detected
- byte_received  output  1  pulse: last data bit sampled
- ack_prep  output  1  pulse: SCL fell after last data bit; ACK bit must be driven now
- ack_check  output  1  pulse: SCL rose in ACK slot; SDA holds ACK/NACK
- ack_done  output  1  pulse: SCL fell ending ACK slot
- bit_count  output  4  data bits sampled in current byte (0..BITS_PER_BYTE)
- framing_active  output  1  high from START until STOP

Behaviour:
- All outputs registered. Reset values: all pulses 0, bit_count 0, framing_active 0, state IDLE.
- Latency: a strobe caused by an input pulse sampled at clk edge N is high during cycle N..N+1 only (exactly 1 cycle).
- States: IDLE, DATA, WAIT_FALL, ACK_LOW, ACK_HIGH.
- IDLE: ignore SCL edges. start_found -> DATA, bit_count<=0, framing_active<=1.
- DATA: scl_rise -> bit_count+1. If the new count == BITS_PER_BYTE: pulse byte_received, go to WAIT_FALL. scl_fall in DATA: no action.
- WAIT_FALL: scl_fall -> pulse ack_prep, go to ACK_LOW.
- ACK_LOW: scl_rise -> pulse ack_check, go to ACK_HIGH.
- ACK_HIGH: scl_fall -> pulse ack_done, bit_count<=0, go to DATA.
- Priority within a cycle: stop_found > start_found > SCL edges.
- stop_found in any state -> IDLE. bit_count<=0, framing_active<=0, no strobe that cycle.
- start_found in any non-IDLE state (repeated START) -> DATA, bit_count<=0, no strobe that cycle.
- scl_rise and scl_fall high in the same cycle is illegal: scl_rise is processed, scl_fall is dropped.
- bit_count never exceeds BITS_PER_BYTE; it holds its value through WAIT_FALL/ACK_LOW/ACK_HIGH.
- Asynchronous reset mid-byte returns to IDLE immediately. The next byte requires a new start_found.
- At most one strobe output is high in any cycle.

Optional Feature:
- Macro I2C_BIT_TIMER_TIMEOUT_EN.
- Defined: adds parameter TIMEOUT_CYCLES (default 1000) and output timeout (1 bit, reset 0).
  - A 16-bit counter clears on any scl_rise, scl_fall, start_found or stop_found, and counts while state != IDLE.
  - On reaching TIMEOUT_CYCLES: pulse timeout for 1 cycle, go to IDLE, bit_count<=0, framing_active<=0.
- Not defined: no counter and no timeout port; the FSM waits indefinitely.

Test Plan:
- Reset, then start_found, 8 scl_rise/scl_fall pairs -> bit_count 1..8; byte_received 1 cycle after 8th rise; ack_prep 1 cycle after next fall; ack_check after 9th rise; ack_done after 9th fall; bit_count returns to 0.
- Two back-to-back bytes, no STOP -> exactly 2 each of byte_received/ack_prep/ack_check/ack_done; framing_active stays 1.
- start_found after 5th rise -> bit_count 0, no strobes; 8 further rises -> byte_received fires on the 8th.
- stop_found in ACK_LOW -> IDLE, framing_active 0, no ack_check; subsequent scl_rise pulses produce no output.
- n_rst low after 3rd rise -> all outputs 0 immediately; edges without start_found stay ignored.
- With I2C_BIT_TIMER_TIMEOUT_EN, TIMEOUT_CYCLES=20: start_found then no SCL edges -> timeout pulse at cycle 20, state IDLE; edge every 10 cycles -> no timeout.
